rs_result_axis_packer: RTL and testbench

- Return path of the RS decoder. Captures each decoder result: the 105-bit corrected word, the error count and the new-packet flag.
- Buffers results in a small synchronous FIFO and serialises each one as a two-beat AXI-Stream master packet towards the DMA/stream fabric.
- The decoder cannot be stalled, so results that arrive while the FIFO is full are dropped and counted.

---
 rtl/rs_result_pkg.sv | 34 +++
 rtl/rs_result_fifo.sv | 54 +++++
 rtl/rs_result_axis_packer.sv | 145 ++++++++++++++
 tb/tb_rs_result_axis_packer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rs_result_pkg.sv
// Shared widths, entry layout, keep masks and FSM states for the RS result return path.
package rs_result_pkg;

  localparam int unsigned RS_DATA_W   = 105;
  localparam int unsigned RS_ERR_W    = 3;
  localparam int unsigned AXIS_DATA_W = 64;
  localparam int unsigned AXIS_KEEP_W = AXIS_DATA_W / 8;
  localparam int unsigned ENTRY_W     = 109;
  localparam int unsigned SEQ_W       = 16;

  // Entry layout: {pkt_new, pkt_errors, pkt_dta}
  localparam int unsigned ENTRY_DTA_LSB = 0;
  localparam int unsigned ENTRY_ERR_LSB = RS_DATA_W;
  localparam int unsigned ENTRY_NEW_LSB = RS_DATA_W + RS_ERR_W;

  // Bits above the beat-0 slice; they already sit in beat-1 order {new, errors, dta[104:64]}
  localparam int unsigned HOLD_W = ENTRY_W - AXIS_DATA_W;

  localparam logic [AXIS_KEEP_W-1:0] TKEEP_FULL = 8'hFF;
  localparam logic [AXIS_KEEP_W-1:0] TKEEP_LAST = 8'h3F;

  typedef enum logic [1:0] {
    IDLE,
    BEAT0,
    BEAT1
  } pkt_state_e;

  // Beat 1 payload: sequence number on top, zero pad, then the held upper entry bits
  function automatic logic [AXIS_DATA_W-1:0] beat1_data(input logic [HOLD_W-1:0] hold,
                                                        input logic [SEQ_W-1:0]  seq);
    return {seq, {(AXIS_DATA_W - SEQ_W - HOLD_W){1'b0}}, hold};
  endfunction

endpackage

// File: rtl/rs_result_fifo.sv
// Generic synchronous FIFO; full/empty come from the level count, pointers wrap naturally.
module rs_result_fifo #(
  parameter int unsigned WIDTH = 109,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH + 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] level_q;

  assign dout_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == FULL_LVL);
  assign empty_o = (level_q == '0);

  // Storage array; no reset needed, validity is tracked by the level
  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

  // Pointer and level bookkeeping with synchronous reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i) begin
        level_q <= level_q + LVL_W'(1);
      end else if (pop_i && !push_i) begin
        level_q <= level_q - LVL_W'(1);
      end
    end
  end

endmodule

// File: rtl/rs_result_axis_packer.sv
// RS decoder result packer: FIFO-buffers results and emits each as a two-beat AXI-Stream packet.
// Optional RS_PKT_SEQ_EN adds a 16-bit packet sequence number in beat 1 tdata[63:48].
module rs_result_axis_packer
  import rs_result_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DROP_CNT_W = 16
) (
  input  logic                       m_axis_aclk,
  input  logic                       m_axis_aresetn,
  input  logic                       pkt_vld,
  input  logic [RS_DATA_W-1:0]       pkt_dta,
  input  logic                       pkt_new,
  input  logic [RS_ERR_W-1:0]        pkt_errors,
  output logic [AXIS_DATA_W-1:0]     m_axis_tdata,
  output logic [AXIS_KEEP_W-1:0]     m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH+1)-1:0] fifo_level,
  output logic [DROP_CNT_W-1:0]      drop_cnt,
  output logic                       busy
);

  logic [ENTRY_W-1:0]     fifo_din;
  logic [ENTRY_W-1:0]     fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;

  pkt_state_e             state_q;
  logic [HOLD_W-1:0]      hold_q;
  logic [AXIS_DATA_W-1:0] tdata_q;
  logic [AXIS_KEEP_W-1:0] tkeep_q;
  logic                   tlast_q;
  logic                   tvalid_q;
  logic [DROP_CNT_W-1:0]  drop_q;
  logic [SEQ_W-1:0]       seq_val;

`ifdef RS_PKT_SEQ_EN
  localparam logic [AXIS_KEEP_W-1:0] TKEEP_B1 = TKEEP_FULL;
  logic [SEQ_W-1:0] seq_q;

  // Sequence number advances once per completed packet (beat-1 handshake), wrapping naturally
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      seq_q <= '0;
    end else if (state_q == BEAT1 && tvalid_q && m_axis_tready) begin
      seq_q <= seq_q + SEQ_W'(1);
    end
  end
  assign seq_val = seq_q;
`else
  localparam logic [AXIS_KEEP_W-1:0] TKEEP_B1 = TKEEP_LAST;
  assign seq_val = '0;
`endif

  // Pack the decoder result into a FIFO entry
  always_comb begin
    fifo_din = '0;
    fifo_din[ENTRY_DTA_LSB +: RS_DATA_W] = pkt_dta;
    fifo_din[ENTRY_ERR_LSB +: RS_ERR_W]  = pkt_errors;
    fifo_din[ENTRY_NEW_LSB]              = pkt_new;
  end

  // Pop when idle, or right at the beat-1 handshake so packets stream back-to-back
  assign pop  = !fifo_empty &&
                ((state_q == IDLE) || (state_q == BEAT1 && m_axis_tready));
  // A full FIFO still accepts a result if the head leaves on the same edge
  assign push = pkt_vld && (!fifo_full || pop);

  rs_result_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (m_axis_aclk),
    .rst_ni  (m_axis_aresetn),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (pop),
    .dout_o  (fifo_dout),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Beat FSM with registered AXI-Stream outputs
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (pop) begin
      hold_q   <= fifo_dout[ENTRY_W-1:AXIS_DATA_W];
      tdata_q  <= fifo_dout[AXIS_DATA_W-1:0];
      tkeep_q  <= TKEEP_FULL;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b1;
      state_q  <= BEAT0;
    end else begin
      unique case (state_q)
        IDLE: ;
        BEAT0: begin
          if (m_axis_tready) begin
            tdata_q <= beat1_data(hold_q, seq_val);
            tkeep_q <= TKEEP_B1;
            tlast_q <= 1'b1;
            state_q <= BEAT1;
          end
        end
        BEAT1: begin
          if (m_axis_tready) begin
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Saturating count of results lost to a full FIFO
  always_ff @(posedge m_axis_aclk) begin
    if (!m_axis_aresetn) begin
      drop_q <= '0;
    end else if (pkt_vld && !push && (drop_q != '1)) begin
      drop_q <= drop_q + DROP_CNT_W'(1);
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tkeep  = tkeep_q;
  assign m_axis_tlast  = tlast_q;
  assign m_axis_tvalid = tvalid_q;
  assign drop_cnt      = drop_q;
  assign busy          = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_rs_result_axis_packer.sv
// Self-checking bench for rs_result_axis_packer: directed scenarios plus random traffic
// against a queue-based reference model of the result path.
module tb_rs_result_axis_packer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DROPW = 16;

  logic         clk = 1'b0;
  logic         rstn;
  logic         pkt_vld;
  logic [104:0] pkt_dta;
  logic         pkt_new;
  logic [2:0]   pkt_errors;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic [2:0]   fifo_level;
  logic [15:0]  drop_cnt;
  logic         busy;

  rs_result_axis_packer #(
    .DEPTH      (DEPTH),
    .DROP_CNT_W (DROPW)
  ) dut (
    .m_axis_aclk    (clk),
    .m_axis_aresetn (rstn),
    .pkt_vld        (pkt_vld),
    .pkt_dta        (pkt_dta),
    .pkt_new        (pkt_new),
    .pkt_errors     (pkt_errors),
    .m_axis_tdata   (tdata),
    .m_axis_tkeep   (tkeep),
    .m_axis_tlast   (tlast),
    .m_axis_tvalid  (tvalid),
    .m_axis_tready  (tready),
    .fifo_level     (fifo_level),
    .drop_cnt       (drop_cnt),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: results queue, result on the wire, beat position (0 none, 1 first, 2 second)
  logic [108:0] mq[$];
  logic [108:0] mcur;
  int           mbeat;
  int           mdrop;
  logic [15:0]  mseq;
  int           msz;
  bit           mhs;
  bit           mpop;

  always @(posedge clk) begin
    if (!rstn) begin
      mq.delete();
      mcur  = '0;
      mbeat = 0;
      mdrop = 0;
      mseq  = '0;
    end else begin
      msz  = mq.size();
      mhs  = (mbeat != 0) && tready;
      mpop = (msz > 0) && ((mbeat == 0) || (mbeat == 2 && mhs));
      if (mbeat == 1 && mhs) begin
        mbeat = 2;
      end else if (mbeat == 2 && mhs) begin
        mseq  = mseq + 16'd1;
        mbeat = mpop ? 1 : 0;
      end else if (mbeat == 0 && mpop) begin
        mbeat = 1;
      end
      if (mpop) mcur = mq.pop_front();
      if (pkt_vld) begin
        if (msz < DEPTH || mpop) mq.push_back({pkt_new, pkt_errors, pkt_dta});
        else if (mdrop < 65535) mdrop++;
      end
    end
  end

  bit          chk_en = 1'b0;
  int          hs_cnt = 0;
  bit          str_en = 1'b0;
  bit          str_seen;
  int          str_gaps;
  logic [63:0] exp_b1;

  // Per-cycle comparison against the model plus handshake / gap monitors
  always @(negedge clk) begin
    if (chk_en) begin
      check_eq("m_tvalid", tvalid, mbeat != 0);
      if (mbeat == 1) begin
        check_eq("m_b0_tdata", tdata, mcur[63:0]);
        check_eq("m_b0_tkeep", tkeep, 8'hFF);
        check_eq("m_b0_tlast", tlast, 1'b0);
      end else if (mbeat == 2) begin
        exp_b1 = '0;
        exp_b1[40:0]  = mcur[104:64];
        exp_b1[43:41] = mcur[107:105];
        exp_b1[44]    = mcur[108];
`ifdef RS_PKT_SEQ_EN
        exp_b1[63:48] = mseq;
        check_eq("m_b1_tkeep", tkeep, 8'hFF);
`else
        check_eq("m_b1_tkeep", tkeep, 8'h3F);
`endif
        check_eq("m_b1_tdata", tdata, exp_b1);
        check_eq("m_b1_tlast", tlast, 1'b1);
      end
      check_eq("m_level", fifo_level, mq.size());
      check_eq("m_drop", drop_cnt, mdrop);
      check_eq("m_busy", busy, (mq.size() > 0) || (mbeat != 0));
      if (tvalid && tready) hs_cnt++;
      if (str_en) begin
        if (tvalid) str_seen = 1'b1;
        else if (str_seen && hs_cnt < 16) str_gaps++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_result();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    pkt_dta    = r[104:0];
    pkt_errors = 3'($urandom_range(0, 7));
    pkt_new    = 1'($urandom_range(0, 1));
  endtask

  logic [104:0] d1;

  initial begin
    rstn       = 1'b0;
    pkt_vld    = 1'b0;
    pkt_dta    = '0;
    pkt_new    = 1'b0;
    pkt_errors = '0;
    tready     = 1'b0;
    tick();
    tick();
    check_eq("rst_tvalid", tvalid, 1'b0);
    check_eq("rst_tdata", tdata, 64'h0);
    check_eq("rst_tkeep", tkeep, 8'h0);
    check_eq("rst_tlast", tlast, 1'b0);
    check_eq("rst_level", fifo_level, 3'd0);
    check_eq("rst_drop", drop_cnt, 16'd0);
    check_eq("rst_busy", busy, 1'b0);
    chk_en = 1'b1;
    rstn   = 1'b1;
    tick();

    // Single result with latency and field checks
    d1         = 105'h1_23456789AB_CDEF0123456789;
    tready     = 1'b1;
    pkt_dta    = d1;
    pkt_errors = 3'd2;
    pkt_new    = 1'b1;
    pkt_vld    = 1'b1;
    tick();
    pkt_vld = 1'b0;
    check_eq("lat_n1_tvalid", tvalid, 1'b0);
    tick();
    check_eq("lat_n2_tvalid", tvalid, 1'b1);
    check_eq("single_b0_tdata", tdata, 64'hABCDEF0123456789);
    check_eq("single_b0_tlast", tlast, 1'b0);
    tick();
    check_eq("single_b1_dta", tdata[40:0], 41'h123456789);
    check_eq("single_b1_err", tdata[43:41], 3'd2);
    check_eq("single_b1_new", tdata[44], 1'b1);
    check_eq("single_b1_tlast", tlast, 1'b1);
    tick();
    check_eq("single_done_tvalid", tvalid, 1'b0);

    // Backpressure: beat 0 held 10 cycles, then exactly two beats
    tready  = 1'b0;
    pkt_dta = d1 ^ 105'h5A5A;
    pkt_vld = 1'b1;
    tick();
    pkt_vld = 1'b0;
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_hold_tdata", tdata, d1[63:0] ^ 64'h5A5A);
      check_eq("bp_hold_tkeep", tkeep, 8'hFF);
      check_eq("bp_hold_tlast", tlast, 1'b0);
      check_eq("bp_hold_tvalid", tvalid, 1'b1);
    end
    hs_cnt = 0;
    tready = 1'b1;
    repeat (6) tick();
    check_eq("bp_beats", hs_cnt, 2);

    // Overflow: seven back-to-back results with the sink stalled
    tready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      rand_result();
      pkt_vld = 1'b1;
      tick();
    end
    pkt_vld = 1'b0;
    tick();
    check_eq("ovf_level", fifo_level, 3'd4);
    check_eq("ovf_drop", drop_cnt, 16'd2);
    hs_cnt = 0;
    tready = 1'b1;
    repeat (16) tick();
    check_eq("ovf_beats", hs_cnt, 10);

    // Streaming: eight results two cycles apart give 16 gap-free beats
    rstn = 1'b0;
    tick();
    rstn     = 1'b1;
    hs_cnt   = 0;
    str_seen = 1'b0;
    str_gaps = 0;
    str_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_result();
      pkt_vld = 1'b1;
      tick();
      pkt_vld = 1'b0;
      tick();
    end
    repeat (6) tick();
    str_en = 1'b0;
    check_eq("str_beats", hs_cnt, 16);
    check_eq("str_gaps", str_gaps, 0);
    check_eq("str_drop", drop_cnt, 16'd0);
    check_eq("str_busy", busy, 1'b0);

    // Reset in beat 1 with two entries queued
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_result();
      pkt_vld = 1'b1;
      tick();
    end
    pkt_vld = 1'b0;
    tready  = 1'b1;
    tick();
    tready = 1'b0;
    check_eq("rmp_in_beat1", tlast, 1'b1);
    check_eq("rmp_pre_level", fifo_level, 3'd2);
    rstn = 1'b0;
    tick();
    check_eq("rmp_tvalid", tvalid, 1'b0);
    check_eq("rmp_level", fifo_level, 3'd0);
    check_eq("rmp_drop", drop_cnt, 16'd0);
    rstn   = 1'b1;
    tready = 1'b1;
    hs_cnt = 0;
    rand_result();
    pkt_vld = 1'b1;
    tick();
    pkt_vld = 1'b0;
    repeat (6) tick();
    check_eq("rmp_after_beats", hs_cnt, 2);

    // Random traffic and backpressure against the model
    for (int i = 0; i < 600; i++) begin
      rand_result();
      pkt_vld = ($urandom_range(0, 99) < 45);
      tready  = ($urandom_range(0, 99) < 60);
      tick();
    end
    pkt_vld = 1'b0;
    tready  = 1'b1;
    repeat (20) tick();
    check_eq("rand_drain_busy", busy, 1'b0);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
